if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit.sv | 113 +++++++++++
 tb/tb_if_fetch_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: memory instruction port, ID handshake and EX redirect.
// Signal prefixes are taken from the fetch unit's point of view.
interface if_fetch_unit_if;
  logic [31:0] o_instrAddr;
  logic        o_en_IF;
  logic [31:0] i_instr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        i_redirect;
  logic [31:0] i_redirectPC;
  logic        o_fault;
  logic [31:0] o_faultPC;

  modport master (
    output o_instrAddr, o_en_IF, o_valid, o_pc, o_instr, o_fault, o_faultPC,
    input  i_instr, i_ready, i_redirect, i_redirectPC
  );

  modport slave (
    input  o_instrAddr, o_en_IF, o_valid, o_pc, o_instr, o_fault, o_faultPC,
    output i_instr, i_ready, i_redirect, i_redirectPC
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to a memory with a
// one-cycle registered read, buffers returns in a 2-entry FIFO toward decode,
// and handles EX redirects (misaligned targets lock the unit in FAULT).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  if_fetch_unit_if.master bus
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] q_pc_q    [2];
  logic [31:0] q_instr_q [2];
  logic [31:0] q_pc_d    [2];
  logic [31:0] q_instr_d [2];

  // Fetch in flight: issued last cycle, data arrives from memory this cycle.
  logic        vld_p1, vld_p1_d;
  logic [31:0] pc_p1, pc_p1_d;

  logic run, redirect, pop, issue, push, wr_sel;

  // Next-state logic: redirect has priority over pop/push/issue; reset gates issue.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    q_pc_d     = q_pc_q;
    q_instr_d  = q_instr_q;
    vld_p1_d   = 1'b0;
    pc_p1_d    = pc_p1;
    wr_sel     = 1'b0;

    run         = (state_q == RUN);
    redirect    = run & bus.i_redirect;
    bus.o_valid = run && (count_q != 2'd0) && !bus.i_redirect;
    pop         = bus.o_valid & bus.i_ready;
    push        = run & vld_p1 & ~bus.i_redirect;
    // Credit: queued + in-flight entries, net of this cycle's pop, must leave room.
    issue       = run && !i_reset && !bus.i_redirect &&
                  (({1'b0, count_q} + {2'b00, vld_p1} - {2'b00, pop}) < 3'd2);

    if (redirect) begin
      count_d = 2'd0;
      if (bus.i_redirectPC[1:0] != 2'b00) begin
        state_d    = FAULT;
        fault_pc_d = bus.i_redirectPC;
      end else begin
        pc_d = bus.i_redirectPC;
      end
    end else if (run) begin
      if (pop) begin
        q_pc_d[0]    = q_pc_q[1];
        q_instr_d[0] = q_instr_q[1];
      end
      // Slot 1 is written only when one entry remains after the pop.
      wr_sel = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
      if (push) begin
        q_pc_d[wr_sel]    = pc_p1;
        q_instr_d[wr_sel] = bus.i_instr;
      end
      count_d = count_q - {1'b0, pop} + {1'b0, push};
      if (issue) begin
        pc_d     = pc_q + 32'd4;
        vld_p1_d = 1'b1;
        pc_p1_d  = pc_q;
      end
    end

    bus.o_en_IF     = issue;
    bus.o_instrAddr = pc_q;
    bus.o_pc        = q_pc_q[0];
    bus.o_instr     = q_instr_q[0];
    bus.o_fault     = (state_q == FAULT);
    bus.o_faultPC   = fault_pc_q;
  end

  // State, PC, queue and in-flight valid registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      fault_pc_q   <= 32'h0;
      count_q      <= 2'd0;
      vld_p1       <= 1'b0;
      q_pc_q[0]    <= RESET_PC;
      q_pc_q[1]    <= RESET_PC;
      q_instr_q[0] <= 32'h0;
      q_instr_q[1] <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
      vld_p1     <= vld_p1_d;
      q_pc_q     <= q_pc_d;
      q_instr_q  <= q_instr_d;
    end
  end

  // In-flight PC is qualified by vld_p1, so it needs no reset.
  always_ff @(posedge i_clk) begin
    pc_p1 <= pc_p1_d;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_unit_if bus0();
  if_fetch_unit_if bus1();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0));
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1));

  logic [31:0] mem [8192];

  // Registered-read memories; output is scrambled when not enabled so hold is never relied upon.
  always @(posedge clk) begin
    if (bus0.o_en_IF) bus0.i_instr <= mem[bus0.o_instrAddr[14:2]];
    else              bus0.i_instr <= $urandom;
    if (bus1.o_en_IF) bus1.i_instr <= mem[bus1.o_instrAddr[14:2]];
    else              bus1.i_instr <= $urandom;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: fetched-but-not-consumed instructions with their issue cycle.
  int          cyc = 0;
  logic [31:0] fetch_pc;
  logic        faulted;
  logic [31:0] flt_pc;
  logic [31:0] q_pc [$];
  int          q_ic [$];

  // Second instance (wrapping reset PC): simple in-order stream expectation.
  logic        check1;
  logic [31:0] exp1_pc, exp1_addr;
  int          n1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_ic.delete();
    fetch_pc  = 32'h0;
    faulted   = 1'b0;
    flt_pc    = 32'h0;
    exp1_pc   = 32'hFFFF_FFF8;
    exp1_addr = 32'hFFFF_FFF8;
  endtask

  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input logic r);
    logic ev, pop, en;
    logic [31:0] hp;
    ev = 1'b0; pop = 1'b0; en = 1'b0;
    rst               = r;
    bus0.i_ready      = rdy;   bus1.i_ready      = rdy;
    bus0.i_redirect   = redir; bus1.i_redirect   = redir;
    bus0.i_redirectPC = rpc;   bus1.i_redirectPC = rpc;
    @(negedge clk);
    if (!r) begin
      if (faulted) begin
        chk("flt_en", bus0.o_en_IF, 1'b0);
        chk("flt_valid", bus0.o_valid, 1'b0);
        chk("flt_fault", bus0.o_fault, 1'b1);
        chk("flt_pc", bus0.o_faultPC, flt_pc);
      end else begin
        ev  = !redir && (q_pc.size() > 0) && (cyc - q_ic[0] >= 2);
        pop = ev && rdy;
        en  = !redir && ((q_pc.size() - (pop ? 1 : 0)) < 2);
        chk("valid", bus0.o_valid, ev);
        if (ev) begin
          hp = q_pc[0];
          chk("head_pc", bus0.o_pc, hp);
          chk("head_instr", bus0.o_instr, mem[hp[14:2]]);
        end
        chk("en", bus0.o_en_IF, en);
        if (en) chk("addr", bus0.o_instrAddr, fetch_pc);
        chk("nofault", bus0.o_fault, 1'b0);
      end
      if (check1) begin
        if (bus1.o_valid && rdy) begin
          chk("wrap_pc", bus1.o_pc, exp1_pc);
          chk("wrap_instr", bus1.o_instr, mem[exp1_pc[14:2]]);
          exp1_pc += 32'd4;
          n1++;
        end
        if (bus1.o_en_IF) begin
          chk("wrap_addr", bus1.o_instrAddr, exp1_addr);
          exp1_addr += 32'd4;
        end
      end
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (!faulted) begin
      if (redir) begin
        q_pc.delete();
        q_ic.delete();
        if (rpc[1:0] != 2'b00) begin
          faulted = 1'b1;
          flt_pc  = rpc;
        end else begin
          fetch_pc = rpc;
        end
      end else begin
        if (pop) begin
          void'(q_pc.pop_front());
          void'(q_ic.pop_front());
        end
        if (en) begin
          q_pc.push_back(fetch_pc);
          q_ic.push_back(cyc);
          fetch_pc += 32'd4;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic chk_reset_values();
    chk("rst_valid", bus0.o_valid, 1'b0);
    chk("rst_pc", bus0.o_pc, 32'h0);
    chk("rst_instr", bus0.o_instr, 32'h0);
    chk("rst_fault", bus0.o_fault, 1'b0);
    chk("rst_faultpc", bus0.o_faultPC, 32'h0);
    chk("rst_addr", bus0.o_instrAddr, 32'h0);
    chk("rst_pc1", bus1.o_pc, 32'hFFFF_FFF8);
  endtask

  initial begin
    logic [31:0] rpc;
    logic        rr, rd, rs;
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    check1 = 1'b0;
    n1 = 0;
    model_reset();
    rst = 1'b1;
    bus0.i_ready = 1'b0; bus1.i_ready = 1'b0;
    bus0.i_redirect = 1'b0; bus1.i_redirect = 1'b0;
    bus0.i_redirectPC = 32'h0; bus1.i_redirectPC = 32'h0;

    // Reset, then free-run with decode always ready
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check1 = 1'b1;
    bus0.i_ready = 1'b1;
    chk_reset_values();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_count", (n1 >= 3) ? 32'd1 : 32'd0, 32'd1);
    check1 = 1'b0;

    // Decode stall for 5 cycles from cycle 3, then release
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect with a full queue, then redirect mid-stream
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Misaligned redirect locks up until reset
    step(1'b1, 1'b1, 32'h0000_0102, 1'b0);
    chk("fault_set", bus0.o_fault, 1'b1);
    chk("fault_pc_set", bus0.o_faultPC, 32'h0000_0102);
    for (int i = 0; i < 8; i++) begin
      rpc = $urandom;
      rpc[1:0] = 2'b00;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rpc, 1'b0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk_reset_values();

    // Reset one cycle after an issue, and again while data returns
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rr  = ($urandom_range(0, 99) < 65);
      rd  = ($urandom_range(0, 99) < 6);
      rs  = ($urandom_range(0, 99) < 3);
      rpc = $urandom;
      rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0;
      step(rr, rd, rpc, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
